// File: rtl/pacman_pkg.sv
// Shared direction/state types and default geometry for the Pac-Man actor mover.
// Optional build macro used by the mover files: PACMAN_MOVER_TUNNEL_WRAP_EN.
package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef logic [2:0] mover_state_t;

    localparam mover_state_t ST_IDLE    = 3'd0;
    localparam mover_state_t ST_RD_WANT = 3'd1;
    localparam mover_state_t ST_EV_WANT = 3'd2;
    localparam mover_state_t ST_RD_CUR  = 3'd3;
    localparam mover_state_t ST_EV_CUR  = 3'd4;
    localparam mover_state_t ST_STEP    = 3'd5;

    localparam int DEF_MAP_W_TILES = 32;
    localparam int DEF_MAP_H_TILES = 24;
    localparam int DEF_TILE        = 20;
    localparam int DEF_SPEED       = 5;
    localparam int DEF_START_TX    = 14;
    localparam int DEF_START_TY    = 17;

    // Up/down and left/right pairs differ only in bit 0.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/pacman_neighbour_addr.sv
// Combinational neighbour-tile address: tile coordinate plus direction to {addr, off_map}.
// With PACMAN_MOVER_TUNNEL_WRAP_EN defined, left/right edges wrap to the opposite column.
module pacman_neighbour_addr
    import pacman_pkg::*;
#(
    parameter int MAP_W_TILES = DEF_MAP_W_TILES,
    parameter int MAP_H_TILES = DEF_MAP_H_TILES,
    parameter int TX_W        = 10,
    parameter int TY_W        = 9,
    parameter int ADDR_W      = $clog2(MAP_W_TILES * MAP_H_TILES)
) (
    input  logic [TX_W-1:0]   tile_x,
    input  logic [TY_W-1:0]   tile_y,
    input  logic [1:0]        dir,
    output logic [ADDR_W-1:0] addr,
    output logic              off_map
);

    logic [31:0] cx;
    logic [31:0] cy;
    logic [31:0] nx;
    logic [31:0] ny;

    always_comb begin
        cx      = 32'(tile_x);
        cy      = 32'(tile_y);
        nx      = cx;
        ny      = cy;
        off_map = 1'b0;
        case (dir)
            DIR_UP: begin
                if (cy == 32'd0) off_map = 1'b1;
                else             ny = cy - 32'd1;
            end
            DIR_DOWN: begin
                if (cy == 32'(MAP_H_TILES - 1)) off_map = 1'b1;
                else                            ny = cy + 32'd1;
            end
            DIR_LEFT: begin
                if (cx == 32'd0) begin
`ifdef PACMAN_MOVER_TUNNEL_WRAP_EN
                    nx = 32'(MAP_W_TILES - 1);
`else
                    off_map = 1'b1;
`endif
                end else begin
                    nx = cx - 32'd1;
                end
            end
            default: begin
                if (cx == 32'(MAP_W_TILES - 1)) begin
`ifdef PACMAN_MOVER_TUNNEL_WRAP_EN
                    nx = 32'd0;
`else
                    off_map = 1'b1;
`endif
                end else begin
                    nx = cx + 32'd1;
                end
            end
        endcase
        addr = ADDR_W'(ny * 32'(MAP_W_TILES) + nx);
    end

endmodule

// File: rtl/pacman_mover.sv
// Tile-grid actor mover: buffers the wanted direction, turns only when tile-aligned,
// checks walls through a 1-cycle tilemap port. Optional macro: PACMAN_MOVER_TUNNEL_WRAP_EN.
module pacman_mover
    import pacman_pkg::*;
#(
    parameter int MAP_W_TILES = DEF_MAP_W_TILES,
    parameter int MAP_H_TILES = DEF_MAP_H_TILES,
    parameter int TILE        = DEF_TILE,
    parameter int SPEED       = DEF_SPEED,
    parameter int START_TX    = DEF_START_TX,
    parameter int START_TY    = DEF_START_TY,
    parameter int X_W         = $clog2(MAP_W_TILES * TILE),
    parameter int Y_W         = $clog2(MAP_H_TILES * TILE),
    parameter int ADDR_W      = $clog2(MAP_W_TILES * MAP_H_TILES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w,
    input  logic              a,
    input  logic              s,
    input  logic              d,
    input  logic              move_tick,
    output logic              tile_rd_en,
    output logic [ADDR_W-1:0] tile_addr,
    input  logic              tile_road,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [1:0]        dir,
    output logic              moving,
    output logic              eat_valid,
    output logic [ADDR_W-1:0] eat_addr,
    output logic              busy,
    output logic              tick_overrun
);

    localparam int X_MAX = (MAP_W_TILES - 1) * TILE;
    localparam int Y_MAX = (MAP_H_TILES - 1) * TILE;
    localparam logic [X_W-1:0] START_X = X_W'(START_TX * TILE);
    localparam logic [Y_W-1:0] START_Y = Y_W'(START_TY * TILE);

    mover_state_t      state;
    dir_t              cur_dir;
    dir_t              want_dir;
    dir_t              look_dir;
    dir_t              nb_dir;
    logic              look_off;
    logic              aligned;
    logic              road_ok;
    logic [X_W-1:0]    tile_x;
    logic [Y_W-1:0]    tile_y;
    logic [ADDR_W-1:0] nb_addr;
    logic              nb_off;
    int                step_x;
    int                step_y;
    logic              step_ok;
    logic              step_aligned;
    logic [ADDR_W-1:0] step_addr;

    assign dir     = cur_dir;
    assign busy    = (state != ST_IDLE);
    assign tile_x  = X_W'(32'(x) / TILE);
    assign tile_y  = Y_W'(32'(y) / TILE);
    assign aligned = ((32'(x) % TILE) == 0) && ((32'(y) % TILE) == 0);
    assign nb_dir  = (state == ST_RD_WANT) ? look_dir : cur_dir;
    assign road_ok = tile_road && !look_off;

    // Off-map neighbours never reach the tilemap; their lookup resolves as a wall.
    assign tile_rd_en = ((state == ST_RD_WANT) || (state == ST_RD_CUR)) && !nb_off;
    assign tile_addr  = tile_rd_en ? nb_addr : '0;

    pacman_neighbour_addr #(
        .MAP_W_TILES (MAP_W_TILES),
        .MAP_H_TILES (MAP_H_TILES),
        .TX_W        (X_W),
        .TY_W        (Y_W),
        .ADDR_W      (ADDR_W)
    ) u_neighbour (
        .tile_x  (tile_x),
        .tile_y  (tile_y),
        .dir     (nb_dir),
        .addr    (nb_addr),
        .off_map (nb_off)
    );

    // Candidate position for a step; a step that would leave the map is refused.
    always_comb begin
        step_x = int'(x);
        step_y = int'(y);
        case (cur_dir)
            DIR_UP:   step_y = step_y - SPEED;
            DIR_DOWN: step_y = step_y + SPEED;
            DIR_LEFT: step_x = step_x - SPEED;
            default:  step_x = step_x + SPEED;
        endcase
`ifdef PACMAN_MOVER_TUNNEL_WRAP_EN
        if (step_x < 0)          step_x = X_MAX;
        else if (step_x > X_MAX) step_x = 0;
`endif
        step_ok      = (step_x >= 0) && (step_x <= X_MAX) && (step_y >= 0) && (step_y <= Y_MAX);
        step_aligned = ((step_x % TILE) == 0) && ((step_y % TILE) == 0);
        step_addr    = ADDR_W'((step_y / TILE) * MAP_W_TILES + (step_x / TILE));
    end

    always_ff @(posedge clk) begin
        if (reset)   want_dir <= DIR_LEFT;
        else if (!w) want_dir <= DIR_UP;
        else if (!s) want_dir <= DIR_DOWN;
        else if (!a) want_dir <= DIR_LEFT;
        else if (!d) want_dir <= DIR_RIGHT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            x            <= START_X;
            y            <= START_Y;
            cur_dir      <= DIR_LEFT;
            look_dir     <= DIR_LEFT;
            look_off     <= 1'b0;
            moving       <= 1'b0;
            eat_valid    <= 1'b0;
            eat_addr     <= '0;
            tick_overrun <= 1'b0;
        end else begin
            eat_valid <= 1'b0;
            if (move_tick && (state != ST_IDLE)) tick_overrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (move_tick) begin
                        look_dir <= want_dir;
                        if (want_dir == opposite(cur_dir)) begin
                            cur_dir <= want_dir;
                            state   <= ST_STEP;
                        end else if (!aligned) begin
                            state <= ST_STEP;
                        end else if (want_dir != cur_dir) begin
                            state <= ST_RD_WANT;
                        end else begin
                            state <= ST_RD_CUR;
                        end
                    end
                end
                ST_RD_WANT: begin
                    look_off <= nb_off;
                    state    <= ST_EV_WANT;
                end
                ST_EV_WANT: begin
                    if (road_ok) begin
                        cur_dir <= look_dir;
                        state   <= ST_STEP;
                    end else begin
                        state <= ST_RD_CUR;
                    end
                end
                ST_RD_CUR: begin
                    look_off <= nb_off;
                    state    <= ST_EV_CUR;
                end
                ST_EV_CUR: begin
                    if (road_ok) begin
                        state <= ST_STEP;
                    end else begin
                        moving <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    if (step_ok) begin
                        x      <= X_W'(step_x);
                        y      <= Y_W'(step_y);
                        moving <= 1'b1;
                        if (step_aligned) begin
                            eat_valid <= 1'b1;
                            eat_addr  <= step_addr;
                        end
                    end else begin
                        moving <= 1'b0;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pacman_mover.md
Name: pacman_mover

Overview:
- Parametrised successor to the player movement logic.
- Moves one actor (Pac-Man or a ghost body) on a tile grid, one step per external move tick.
- Buffers the requested direction and turns only when the actor is tile-aligned.
- Queries the tilemap through a 1-cycle-latency read port instead of a flat bus, and reports eaten tiles as one-cycle events to the dot/score logic.

Parameters:
- MAP_W_TILES, 32, map width in tiles
- MAP_H_TILES, 24, map height in tiles
- TILE, 20, tile size in pixels; must be a multiple of SPEED
- SPEED, 5, pixels per step
- START_TX, 14, reset tile column
- START_TY, 17, reset tile row
- X_W, $clog2(MAP_W_TILES*TILE), x width (derived)
- Y_W, $clog2(MAP_H_TILES*TILE), y width (derived)
- ADDR_W, $clog2(MAP_W_TILES*MAP_H_TILES), tile address width (derived)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- w  in  1  up key, active-low
- a  in  1  left key, active-low
- s  in  1  down key, active-low
- d  in  1  right key, active-low
- move_tick  in  1  one-cycle step strobe
- tile_rd_en  out  1  tilemap read request
- tile_addr  out  ADDR_W  tile index, ty*MAP_W_TILES+tx
- tile_road  in  1  read data, valid the cycle after tile_rd_en; 1 = road, 0 = wall
- x  out  X_W  pixel x (top-left of sprite)
- y  out  Y_W  pixel y
- dir  out  2  current direction: 0 up, 1 down, 2 left, 3 right
- moving  out  1  last step moved
- eat_valid  out  1  one-cycle pulse when a step lands aligned on a tile
- eat_addr  out  ADDR_W  index of that tile, valid with eat_valid
- busy  out  1  FSM not in IDLE
- tick_overrun  out  1  sticky; set when move_tick arrives while busy

Behaviour:
- Reset values:
  - x = START_TX*TILE, y = START_TY*TILE
  - dir = 2 and want_dir = 2
  - moving, eat_valid, tile_rd_en, tick_overrun, busy = 0
  - eat_addr = 0, tile_addr = 0
  - FSM = IDLE
- Reset mid-operation aborts the FSM; any tile_road arriving the next cycle is ignored.
- want_dir register:
  - Updated every clk, independent of the FSM, when any key is low.
  - Priority w > s > a > d.
  - Holds its value when no key is pressed.
- Aligned means x%TILE==0 and y%TILE==0. Neighbour tile = current tile ±1 in the given direction.
- A neighbour outside the map is a wall. No read is issued for it; it is evaluated as tile_road=0.
- FSM states: IDLE, RD_WANT, EV_WANT, RD_CUR, EV_CUR, STEP.
  - IDLE:
    - On move_tick, if want_dir is the opposite of dir: set dir=want_dir and go to STEP. Reversal is allowed at any time without a lookup.
    - Else if not aligned: go to STEP with dir unchanged (mid-tile travel needs no check).
    - Else if want_dir != dir: go to RD_WANT.
    - Else: go to RD_CUR.
  - RD_WANT: tile_rd_en=1 with the want neighbour address; go to EV_WANT.
  - EV_WANT: if tile_road=1, set dir=want_dir and go to STEP; else go to RD_CUR.
  - RD_CUR: tile_rd_en=1 with the dir neighbour address; go to EV_CUR.
  - EV_CUR: if tile_road=1, go to STEP; else set moving=0 and go to IDLE.
  - STEP:
    - Apply ±SPEED on the dir axis and set moving=1.
    - If the new position is aligned, pulse eat_valid with eat_addr = new tile index.
    - Go to IDLE.
- Latency: move_tick to position update is 1 cycle minimum, 5 cycles maximum. busy is high in every state except IDLE.
- move_tick while busy is dropped and sets tick_overrun, which clears only on reset. A tick in the same cycle as the return to IDLE is dropped.
- Arithmetic:
  - Tile coordinate = pixel / TILE. Use constant division; no run-time divider.
  - Address multiply is by a constant.
  - No position ever leaves [0, MAP*TILE - TILE].

Optional Feature:
- Macro: PACMAN_MOVER_TUNNEL_WRAP_EN.
- Defined:
  - A left/right neighbour off the map edge wraps to the column on the opposite edge, and is looked up normally.
  - A STEP moving past x=0 going left sets x=(MAP_W_TILES-1)*TILE; past the right edge sets x=0.
  - eat_valid fires for the wrapped tile.
- Undefined: off-map neighbours are walls, as above.

Decomposition:
- Package pacman_pkg:
  - dir_t enum (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3)
  - mover_state_t
  - default map and tile constants
- One sub-module, pacman_neighbour_addr: combinational tile_x/tile_y plus direction to {addr, off_map}, with the wrap logic under the macro.

Test Plan:
- After reset with default parameters, x=280, y=340, dir=2. Apply 4 ticks with a road to the left → x=260, one eat_valid with eat_addr=17*32+13=557, tick-to-update ≤5 cycles.
- Hold w low at x=270 (mid-tile), dir=2 → keeps moving left to 260; the first aligned tick issues a read for address 525. Road → dir=0, y=335.
- From aligned at x=260, dir=2, with a wall at tile 556 and no key pressed → tick gives moving=0 and x unchanged. Press d → the next tick moves immediately to x=265, dir=3, with no tile_rd_en.
- Actor at x=0, y=340 moving left:
  - Without the macro: no tile_rd_en, moving=0.
  - With the macro: x=620, eat_valid with eat_addr=575.
- Second move_tick one cycle after the first → tick_overrun=1 and only one step is applied. Assert reset in EV_WANT → all outputs return to reset values the next cycle.
